// File: rtl/button_irq_master_pkg.sv
// button_irq_master_pkg: FSM states and PIO register addresses for button_irq_master.
package button_irq_master_pkg;
    typedef enum logic [2:0] {
        INIT, IDLE, RD_EDGE, CAP_EDGE, RD_DATA, CAP_DATA, CLEAR, EMIT
    } state_e;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
endpackage

// File: rtl/button_irq_master.sv
// button_irq_master: Avalon-MM master servicing PIO edge interrupts and emitting handshaked events.
module button_irq_master
    import button_irq_master_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] MASK_VAL = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic [31:0]      readdata,
    output logic             chipselect,
    output logic [1:0]       address,
    output logic             write_n,
    output logic [31:0]      writedata,
    output logic             event_valid,
    input  logic             event_ready,
    output logic             event_level,
    output logic             pause_state,
    output logic [CNT_W-1:0] event_count
);
    state_e state_q, state_d;
    logic cs_q, cs_d, wr_n_q, wr_n_d, valid_q, valid_d;
    logic level_q, level_d, pause_q, pause_d;
    logic [1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic unused_rd;

    assign unused_rd = ^readdata[31:1];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        pause_d = pause_q;
        cnt_d   = cnt_q;
        case (state_q)
            // Bus outputs are registered from state_d, so INIT lingers until its write has been driven.
            INIT:     state_d = wr_n_q ? INIT : IDLE;
            IDLE:     state_d = irq ? RD_EDGE : IDLE;
            RD_EDGE:  state_d = CAP_EDGE;
            CAP_EDGE: state_d = readdata[0] ? RD_DATA : IDLE;
            RD_DATA:  state_d = CAP_DATA;
            CAP_DATA: begin
                level_d = readdata[0];
                state_d = CLEAR;
            end
            CLEAR:    state_d = EMIT;
            EMIT: if (event_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + 1'b1;
                pause_d = ~pause_q;
            end
            default:  state_d = INIT;
        endcase
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = ADDR_EDGE;
        wdata_d = 32'h0;
        valid_d = 1'b0;
        case (state_d)
            INIT: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_MASK;
                wdata_d = MASK_VAL;
            end
            RD_EDGE:  cs_d = 1'b1;
            RD_DATA: begin
                cs_d   = 1'b1;
                addr_d = ADDR_DATA;
            end
            CAP_DATA: addr_d = ADDR_DATA;
            CLEAR: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                wdata_d = 32'h1;
            end
            EMIT:     valid_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            addr_q  <= ADDR_DATA;
            wdata_q <= 32'h0;
            valid_q <= 1'b0;
            level_q <= 1'b0;
            pause_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            level_q <= level_d;
            pause_q <= pause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign chipselect  = cs_q;
    assign address     = addr_q;
    assign write_n     = wr_n_q;
    assign writedata   = wdata_q;
    assign event_valid = valid_q;
    assign event_level = level_q;
    assign pause_state = pause_q;
    assign event_count = cnt_q;
endmodule

// File: tb/tb_button_irq_master.sv
// tb_button_irq_master: directed bench with a small PIO slave model for button_irq_master.
module tb_button_irq_master;
    logic clk = 1'b0, reset = 1'b1, event_ready = 1'b0, set_edge = 1'b0, force_irq = 1'b0;
    logic [31:0] readdata = 32'h0, mask_r = 32'h0, edge_r = 32'h0, data_r = 32'h0;
    logic irq, chipselect, write_n, event_valid, event_level, pause_state;
    logic [1:0] address;
    logic [31:0] writedata;
    logic [15:0] event_count;
    logic c2_cs, c2_wn, c2_valid, c2_level, c2_pause;
    logic [1:0] c2_addr, c2_count;
    logic [31:0] c2_wd;
    int wr_cnt = 0, errors = 0, checks = 0, exp_cnt = 0, w = 0;
    logic exp_pause = 1'b0;

    always #5 clk = ~clk;

    button_irq_master dut (
        .clk(clk), .reset(reset), .irq(irq), .readdata(readdata),
        .chipselect(chipselect), .address(address), .write_n(write_n), .writedata(writedata),
        .event_valid(event_valid), .event_ready(event_ready), .event_level(event_level),
        .pause_state(pause_state), .event_count(event_count)
    );

    button_irq_master #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .irq(irq), .readdata(readdata),
        .chipselect(c2_cs), .address(c2_addr), .write_n(c2_wn), .writedata(c2_wd),
        .event_valid(c2_valid), .event_ready(event_ready), .event_level(c2_level),
        .pause_state(c2_pause), .event_count(c2_count)
    );

    // PIO slave: registered reads, write-1-to-clear edge capture, irq = edge & mask
    assign irq = (|(edge_r & mask_r)) | force_irq;
    always @(posedge clk) begin
        readdata <= address == 2'd0 ? data_r : address == 2'd2 ? mask_r : address == 2'd3 ? edge_r : 32'h0;
        if (chipselect && !write_n) begin
            wr_cnt <= wr_cnt + 1;
            if (address == 2'd2) mask_r <= writedata;
        end
        edge_r <= set_edge ? (edge_r | 32'h1) :
                  (chipselect && !write_n && address == 2'd3) ? (edge_r & ~writedata) : edge_r;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        set_edge = 1'b1;
        step;
        set_edge = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chk({tag, "_cs"}, chipselect, cs);
        chk({tag, "_wn"}, write_n, wn);
        chk({tag, "_addr"}, address, a);
        chk({tag, "_wd"}, writedata, wd);
    endtask

    task automatic chk_reset(input string tag);
        chk_bus(tag, 1'b0, 1'b1, 2'd0, 32'h0);
        chk({tag, "_valid"}, event_valid, 0);
        chk({tag, "_level"}, event_level, 0);
        chk({tag, "_pause"}, pause_state, 0);
        chk({tag, "_count"}, event_count, 0);
        chk({tag, "_count2"}, c2_count, 0);
    endtask

    task automatic svc(input logic lvl);
        step; chk_bus("rd_edge", 1'b1, 1'b1, 2'd3, 32'h0);
        step; chk_bus("cap_edge", 1'b0, 1'b1, 2'd3, 32'h0);
        step; chk_bus("rd_data", 1'b1, 1'b1, 2'd0, 32'h0);
        step; chk_bus("cap_data", 1'b0, 1'b1, 2'd0, 32'h0);
        step; chk_bus("clear", 1'b1, 1'b0, 2'd3, 32'h1);
        chk("clear_valid", event_valid, 0);
        step;
        chk("emit_valid", event_valid, 1);
        chk("emit_level", event_level, lvl);
        chk("emit_cs", chipselect, 0);
        chk("edge_cleared", edge_r[0], 0);
    endtask

    task automatic accept;
        event_ready = 1'b1;
        step;
        event_ready = 1'b0;
        exp_cnt++;
        exp_pause = ~exp_pause;
        chk("acc_valid", event_valid, 0);
        chk("acc_count", event_count, exp_cnt);
        chk("acc_pause", pause_state, exp_pause);
        chk("acc_count2", c2_count, exp_cnt % 4);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step;
        chk_reset("rst");
        reset = 1'b0;
        step; chk_bus("init", 1'b1, 1'b0, 2'd2, 32'h1);
        step; chk_bus("idle", 1'b0, 1'b1, 2'd3, 32'h0);
        chk("mask_written", mask_r, 32'h1);
        data_r = 32'h0; pulse; svc(1'b0); accept;
        data_r = 32'h1; pulse; svc(1'b1);
        repeat (10) begin
            step;
            chk("hold_valid", event_valid, 1);
            chk("hold_level", event_level, 1);
            chk("hold_count", event_count, exp_cnt);
        end
        accept;
        w = wr_cnt;
        force_irq = 1'b1; step; force_irq = 1'b0;
        chk_bus("sp_rd", 1'b1, 1'b1, 2'd3, 32'h0);
        step; step;
        chk_bus("sp_idle", 1'b0, 1'b1, 2'd3, 32'h0);
        repeat (3) begin
            step;
            chk("sp_valid", event_valid, 0);
        end
        chk("sp_no_write", wr_cnt, w);
        chk("sp_count", event_count, exp_cnt);
        data_r = 32'h0; pulse; svc(1'b0);
        pulse; accept;
        svc(1'b0); accept;
        data_r = 32'h1; pulse;
        step; step; step;
        chk_bus("pre_rst", 1'b1, 1'b1, 2'd0, 32'h0);
        reset = 1'b1;
        step;
        chk_reset("mid_rst");
        exp_cnt = 0;
        exp_pause = 1'b0;
        reset = 1'b0;
        w = wr_cnt;
        step; chk_bus("reinit", 1'b1, 1'b0, 2'd2, 32'h1);
        step; chk_bus("reidle", 1'b0, 1'b1, 2'd3, 32'h0);
        chk("reinit_write", wr_cnt, w + 1);
        svc(1'b1); accept;
        for (int i = 0; i < 4; i++) begin
            data_r = {31'h0, i[0]};
            pulse; svc(i[0]); accept;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_irq_master.md
BUTTON_IRQ_MASTER -- requirements
Module: button_irq_master

Interface
REQ-001 Parameter CNT_W, default 16: width of the serviced-event counter.
REQ-002 Parameter MASK_VAL, default 32'h1: value written to the PIO interrupt-mask register at init.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq  input  1  interrupt from the PIO slave.
REQ-006 readdata  input  32  PIO slave read data, registered in the slave (valid 1 cycle after address presented).
REQ-007 chipselect  output  1  Avalon-MM slave select toward the PIO.
REQ-008 address  output  2  PIO register address (0 data, 2 irq mask, 3 edge capture).
REQ-009 write_n  output  1  active-low write strobe.
REQ-010 writedata  output  32  write data.
REQ-011 event_valid  output  1  serviced-edge event available.
REQ-012 event_ready  input  1  consumer accepts event when high with event_valid.
REQ-013 event_level  output  1  PIO data bit 0 sampled during service.
REQ-014 pause_state  output  1  toggles once per accepted event.
REQ-015 event_count  output  CNT_W  count of accepted events.

Function
REQ-016 FSM states SHALL be: INIT, IDLE, RD_EDGE, CAP_EDGE, RD_DATA, CAP_DATA, CLEAR, EMIT.
REQ-017 INIT (1 cycle): chipselect=1, write_n=0, address=2, writedata=MASK_VAL; next IDLE.
REQ-018 IDLE: chipselect=0, write_n=1, address=3; on irq=1 go to RD_EDGE, else stay.
REQ-019 RD_EDGE: chipselect=1, write_n=1, address=3; next CAP_EDGE.
REQ-020 CAP_EDGE: address held at 3; sample readdata[0]; if 0 (spurious) go IDLE with no slave write, else go RD_DATA.
REQ-021 RD_DATA: chipselect=1, write_n=1, address=0; next CAP_DATA.
REQ-022 CAP_DATA: address held at 0; register readdata[0] into event_level; next CLEAR.
REQ-023 CLEAR (1 cycle): chipselect=1, write_n=0, address=3, writedata=32'h1; next EMIT.
REQ-024 EMIT: event_valid=1, with event_level stable, until event_ready=1; on that cycle event_count increments, pause_state toggles, next IDLE.
REQ-025 event_valid SHALL be 0 in every state except EMIT.
REQ-026 event_count SHALL wrap from all-ones to 0.
REQ-027 Outside INIT/CLEAR, write_n=1 and writedata=0.
REQ-028 irq asserted during EMIT SHALL NOT be lost: slave holds the capture; servicing starts from IDLE after the handshake.
REQ-029 Minimum service latency, irq high in IDLE to event_valid: 6 cycles.

Reset
REQ-030 While reset=1: state=INIT, chipselect=0, write_n=1, address=0, writedata=0, event_valid=0, event_level=0, pause_state=0, event_count=0.
REQ-031 Reset asserted mid-service SHALL abandon the transaction. After release, INIT SHALL rewrite the mask before any read.

Structure
REQ-032 A shared package SHALL hold the state enum and register-address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3).
REQ-033 No sub-module; a single FSM with registered outputs.

Verification
REQ-034 Reset release, then pio falling edge with data=0 -> INIT mask write 32'h1 at addr 2, then RD_EDGE, CAP_EDGE, RD_DATA, CAP_DATA, and CLEAR write of 32'h1 at addr 3; event_valid with event_level=0; event_ready=1 gives event_count=1, pause_state=1.
REQ-035 irq with edge bit read as 0 -> return to IDLE, no clear write, no event, event_count unchanged.
REQ-036 event_ready held 0 for 10 cycles -> event_valid and event_level stable for 10 cycles; count increments only on the accept cycle.
REQ-037 Second edge while in EMIT -> after the first accept, second service runs; event_count=2, pause_state=0.
REQ-038 Reset pulsed during RD_DATA -> all outputs at reset values the next cycle; INIT mask write reissued.
REQ-039 CNT_W=2 with 5 accepted events -> event_count sequence 1,2,3,0,1.
